// File: rtl/ip_tile_alu_seq_nbit.sv
// Sequential 16-opcode ALU tile with DATA_WIDTH-bit operands.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle; other ops take one cycle.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// EXEC  | computing; abort returns to IDLE without commit
// DONE  | result/flags committed on entry; csr_out_we pulses
module ip_tile_alu_seq_nbit #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic [REG_WIDTH-1:0]     data_reg_a,
  input  logic [REG_WIDTH-1:0]     data_reg_b,
  output logic [REG_WIDTH-1:0]     data_reg_c,
  output logic [CSR_OUT_WIDTH-1:0] csr_out,
  output logic                     csr_in_re,
  output logic                     csr_out_we
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]     ONE_W    = W'(1);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_MUL  = 4'd2,  OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_NOT  = 4'd6,  OP_XOR  = 4'd7;
  localparam logic [3:0] OP_XNOR = 4'd8,  OP_SHL  = 4'd9,  OP_SHR  = 4'd10, OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12, OP_RSUB = 4'd13, OP_ASRA = 4'd14, OP_ASRB = 4'd15;

  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [W-1:0]     a_q, b_q, result_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic [2*W-1:0]   work_q;
  logic [CNT_W-1:0] cnt_q;

  logic           start, abort, accept, commit;
  logic [3:0]     op_in;
  logic [W-1:0]   res_d, simple_res;
  logic [3:0]     flags_d;
  logic [W:0]     add_ext, mul_sum, div_shift, div_diff;
  logic           div_ge;
  logic [2*W-1:0] mul_next, div_next;
  logic           unused_bits;

  assign start      = csr_in[0];
  assign abort      = csr_in[1];
  assign op_in      = data_reg_a[REG_WIDTH-1 -: 4];
  assign accept     = (state_q == IDLE) && start && !rst;
  assign csr_in_re  = accept;
  assign csr_out_we = (state_q == DONE) && !rst;
  assign unused_bits = ^{csr_in, data_reg_a, data_reg_b};

  assign add_ext = {1'b0, a_q} + {1'b0, b_q};

  // MUL: work holds {partial upper, multiplier bits still to consume}
  assign mul_sum  = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, work_q[W-1:1]};

  // DIV: work holds {remainder, dividend bits shifting into quotient}
  assign div_shift = work_q[2*W-1:W-1];
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = !div_diff[W];
  assign div_next  = div_ge ? {div_diff[W-1:0], work_q[W-2:0], 1'b1}
                            : {div_shift[W-1:0], work_q[W-2:0], 1'b0};

  always_comb begin
    simple_res = '0;
    case (op_q)
      OP_ADD:  simple_res = add_ext[W-1:0];
      OP_SUB:  simple_res = a_q - b_q;
      OP_AND:  simple_res = a_q & b_q;
      OP_OR:   simple_res = a_q | b_q;
      OP_NOT:  simple_res = ~a_q;
      OP_XOR:  simple_res = a_q ^ b_q;
      OP_XNOR: simple_res = ~(a_q ^ b_q);
      OP_SHL:  simple_res = {a_q[W-2:0], 1'b0};
      OP_SHR:  simple_res = {1'b0, a_q[W-1:1]};
      OP_INC:  simple_res = a_q + ONE_W;
      OP_DEC:  simple_res = a_q - ONE_W;
      OP_RSUB: simple_res = b_q - a_q;
      OP_ASRA: simple_res = {a_q[W-1], a_q[W-1:1]};
      OP_ASRB: simple_res = {b_q[W-1], b_q[W-1:1]};
      default: simple_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    res_d   = result_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: if (start) state_d = EXEC;
      EXEC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (op_q == OP_MUL) begin
          if (cnt_q == '0) begin
            commit  = 1'b1;
            res_d   = mul_next[W-1:0];
            flags_d = {|mul_next[2*W-1:W], 3'b000};
            state_d = DONE;
          end
        end else if (op_q == OP_DIV) begin
          if (b_q == '0) begin
            commit  = 1'b1;
            res_d   = '1;
            flags_d = 4'b0010;
            state_d = DONE;
          end else if (cnt_q == '0) begin
            commit  = 1'b1;
            res_d   = div_next[W-1:0];
            flags_d = 4'b0000;
            state_d = DONE;
          end
        end else begin
          commit  = 1'b1;
          res_d   = simple_res;
          flags_d = {1'b0, (op_q == OP_ADD) && add_ext[W], 2'b00};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) flags_d[0] = (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= op_in;
        a_q    <= data_reg_a[W-1:0];
        b_q    <= data_reg_b[W-1:0];
        work_q <= {{W{1'b0}}, (op_in == OP_DIV) ? data_reg_a[W-1:0] : data_reg_b[W-1:0]};
        cnt_q  <= CNT_INIT;
        done_q <= 1'b0;
      end else if (state_q == EXEC && !abort) begin
        work_q <= (op_q == OP_MUL) ? mul_next : div_next;
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
      end
      if (commit) begin
        result_q <= res_d;
        flags_q  <= flags_d;
        done_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    data_reg_c = '0;
    data_reg_c[W-1:0] = result_q;
    data_reg_c[REG_WIDTH-1 -: 4] = flags_q;
  end

  always_comb begin
    csr_out = '0;
    csr_out[0]   = (state_q == EXEC);
    csr_out[1]   = done_q;
    csr_out[5:2] = flags_q;
    csr_out[7:6] = state_q;
  end

endmodule

// File: tb/tb_ip_tile_alu_seq_nbit.sv
// Directed bench for ip_tile_alu_seq_nbit: vector table at W=8 plus W=16 checks
// and hand sequences for held start, abort and mid-operation reset.
module tb_ip_tile_alu_seq_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] csr_in, csr_in16;
  logic [31:0] data_reg_a, data_reg_b;
  logic [31:0] c8, c16;
  logic [15:0] co8, co16;
  logic        re8, we8, re16, we16;

  ip_tile_alu_seq_nbit #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .csr_in(csr_in), .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .data_reg_c(c8), .csr_out(co8), .csr_in_re(re8), .csr_out_we(we8));

  ip_tile_alu_seq_nbit #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .csr_in(csr_in16), .data_reg_a(data_reg_a), .data_reg_b(data_reg_b),
    .data_reg_c(c16), .csr_out(co16), .csr_in_re(re16), .csr_out_we(we16));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_c;
    int          exp_lat;
  } vec_t;

  vec_t vecs[26];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the selected DUT idle.
  task automatic do_op(input bit w16, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat, output logic [31:0] c);
    data_reg_a = {op, a[27:0]};
    data_reg_b = b;
    if (w16) csr_in16 = 16'h0001; else csr_in = 16'h0001;
    #1;
    check("accept_re", {31'b0, (w16 ? re16 : re8)}, 32'd1);
    @(posedge clk); #1;
    csr_in = '0;
    csr_in16 = '0;
    lat = 1;
    while (!(w16 ? we16 : we8) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    c = w16 ? c16 : c8;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int re_count;
    logic [31:0] c;
    logic [1:0] exp_st;
    logic exp_done, exp_busy, saw_we;

    vecs[0]  = '{4'd0,  32'hF0,       32'h20,       32'h4000_0010, 2};
    vecs[1]  = '{4'd2,  32'h10,       32'h10,       32'h9000_0000, 9};
    vecs[2]  = '{4'd3,  32'h64,       32'h07,       32'h0000_000E, 9};
    vecs[3]  = '{4'd3,  32'h05,       32'h00,       32'h2000_00FF, 2};
    vecs[4]  = '{4'd14, 32'h80,       32'h00,       32'h0000_00C0, 2};
    vecs[5]  = '{4'd15, 32'h00,       32'h7F,       32'h0000_003F, 2};
    vecs[6]  = '{4'd1,  32'h05,       32'h07,       32'h0000_00FE, 2};
    vecs[7]  = '{4'd2,  32'h0D,       32'h0B,       32'h0000_008F, 9};
    vecs[8]  = '{4'd2,  32'hFF,       32'hFF,       32'h8000_0001, 9};
    vecs[9]  = '{4'd4,  32'hF0,       32'h3C,       32'h0000_0030, 2};
    vecs[10] = '{4'd5,  32'hF0,       32'h0F,       32'h0000_00FF, 2};
    vecs[11] = '{4'd6,  32'h0F,       32'h00,       32'h0000_00F0, 2};
    vecs[12] = '{4'd7,  32'hAA,       32'hAA,       32'h1000_0000, 2};
    vecs[13] = '{4'd8,  32'hA5,       32'h0F,       32'h0000_0055, 2};
    vecs[14] = '{4'd9,  32'h81,       32'h00,       32'h0000_0002, 2};
    vecs[15] = '{4'd10, 32'h81,       32'h00,       32'h0000_0040, 2};
    vecs[16] = '{4'd11, 32'hFF,       32'h00,       32'h1000_0000, 2};
    vecs[17] = '{4'd12, 32'h00,       32'h00,       32'h0000_00FF, 2};
    vecs[18] = '{4'd13, 32'h03,       32'h10,       32'h0000_000D, 2};
    vecs[19] = '{4'd0,  32'h0ABC_DE01, 32'hFFFF_FF02, 32'h0000_0003, 2};
    vecs[20] = '{4'd3,  32'hFF,       32'h10,       32'h0000_000F, 9};
    vecs[21] = '{4'd3,  32'h07,       32'h09,       32'h1000_0000, 9};
    vecs[22] = '{4'd14, 32'h7F,       32'h00,       32'h0000_003F, 2};
    vecs[23] = '{4'd0,  32'h7F,       32'h01,       32'h0000_0080, 2};
    vecs[24] = '{4'd1,  32'h07,       32'h07,       32'h1000_0000, 2};
    vecs[25] = '{4'd0,  32'h80,       32'h80,       32'h5000_0000, 2};

    // reset with start asserted: nothing may be accepted
    rst = 1'b1;
    csr_in = 16'h0001;
    csr_in16 = '0;
    data_reg_a = '0;
    data_reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_re", {31'b0, re8}, 32'd0);
    check("reset_c", c8, 32'd0);
    check("reset_csr", {16'b0, co8}, 32'd0);
    check("reset_we", {31'b0, we8}, 32'd0);
    check("reset_csr16", {16'b0, co16}, 32'd0);
    rst = 1'b0;
    csr_in = '0;
    @(posedge clk); #1;

    // start held across three ADDs: IDLE/EXEC/DONE repeating
    data_reg_a = {4'd0, 28'h1};
    data_reg_b = 32'h1;
    csr_in = 16'h0001;
    re_count = 0;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_st   = (k % 3 == 0) ? 2'b00 : (k % 3 == 1) ? 2'b01 : 2'b10;
      exp_done = (k % 3 == 2) || (k % 3 == 0 && k > 0);
      exp_busy = (k % 3 == 1);
      check($sformatf("held_csr_%0d", k), {16'b0, co8}, {24'b0, exp_st, 4'b0000, exp_done, exp_busy});
      check($sformatf("held_re_%0d", k), {31'b0, re8}, {31'b0, (k % 3 == 0)});
      check($sformatf("held_we_%0d", k), {31'b0, we8}, {31'b0, (k % 3 == 2)});
      if (re8) re_count++;
      if (k == 8) csr_in = '0;
      @(posedge clk); #1;
    end
    check("held_re_count", 32'(re_count), 32'd3);
    check("held_result", c8, 32'h0000_0002);

    for (int i = 0; i < 26; i++) begin
      do_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, lat, c);
      check($sformatf("vec%0d_c", i), c, vecs[i].exp_c);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // start during EXEC is ignored and does not disturb latched operands
    data_reg_a = {4'd2, 28'h0D};
    data_reg_b = 32'h0B;
    csr_in = 16'h0001;
    @(posedge clk); #1;
    csr_in = '0;
    @(posedge clk); #1;
    data_reg_a = {4'd0, 28'hFF};
    data_reg_b = 32'hFF;
    csr_in = 16'h0001;
    #1;
    check("busy_start_re", {31'b0, re8}, 32'd0);
    @(posedge clk); #1;
    csr_in = '0;
    lat = 3;
    while (!we8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_start_lat", 32'(lat), 32'd9);
    check("busy_start_c", c8, 32'h0000_008F);
    @(posedge clk); #1;

    // abort at EXEC cycle 3 of MUL
    do_op(1'b0, 4'd0, 32'h01, 32'h02, lat, c);
    check("pre_abort_c", c, 32'h0000_0003);
    data_reg_a = {4'd2, 28'h10};
    data_reg_b = 32'h10;
    csr_in = 16'h0001;
    @(posedge clk); #1;
    csr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    csr_in = 16'h0002;
    #1;
    check("abort_in_exec", {30'b0, co8[7:6]}, 32'd1);
    @(posedge clk); #1;
    csr_in = '0;
    check("abort_csr", {16'b0, co8}, 32'd0);
    check("abort_we", {31'b0, we8}, 32'd0);
    check("abort_c", c8, 32'h0000_0003);
    saw_we = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (we8) saw_we = 1'b1;
    end
    check("abort_no_we", {31'b0, saw_we}, 32'd0);

    // abort on the final MUL iteration wins over completion
    csr_in = 16'h0001;
    @(posedge clk); #1;
    csr_in = '0;
    repeat (7) @(posedge clk);
    #1;
    csr_in = 16'h0002;
    #1;
    check("abort_last_exec", {30'b0, co8[7:6]}, 32'd1);
    @(posedge clk); #1;
    csr_in = '0;
    check("abort_last_state", {30'b0, co8[7:6]}, 32'd0);
    check("abort_last_we", {31'b0, we8}, 32'd0);
    @(posedge clk); #1;
    check("abort_last_we2", {31'b0, we8}, 32'd0);
    check("abort_last_c", c8, 32'h0000_0003);

    // reset at EXEC cycle 3 of MUL
    csr_in = 16'h0001;
    @(posedge clk); #1;
    csr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_c", c8, 32'd0);
    check("midrst_csr", {16'b0, co8}, 32'd0);
    check("midrst_we", {31'b0, we8}, 32'd0);
    check("midrst_re", {31'b0, re8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(1'b1, 4'd11, 32'hFFFF, 32'h0, lat, c);
    check("w16_inc_c", c, 32'h1000_0000);
    check("w16_inc_lat", 32'(lat), 32'd2);
    do_op(1'b1, 4'd0, 32'hFFFF, 32'h0001, lat, c);
    check("w16_add_c", c, 32'h5000_0000);
    do_op(1'b1, 4'd2, 32'h0100, 32'h0100, lat, c);
    check("w16_mul_c", c, 32'h9000_0000);
    check("w16_mul_lat", 32'(lat), 32'd17);
    do_op(1'b1, 4'd3, 32'hFFFF, 32'h0100, lat, c);
    check("w16_div_c", c, 32'h0000_00FF);
    check("w16_div_lat", 32'(lat), 32'd17);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
